truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 196 +++++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose:
//   Sweeps all eight input combinations of a 3-input combinational gate. Each
//   row is held on dut_in1..3 for SETTLE cycles, and the gate response is then
//   sampled into table_out. Row 000 lands in bit 7 and row 111 in bit 0, so a
//   gate whose truth table is 0x7B produces table_out = 8'h7B.
//
// Parameters:
//   SETTLE      cycles each row is held before sampling (1..255, 0 acts as 1)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       one-cycle sweep request, honoured in IDLE only
//   abort       synchronous cancel of a running sweep (APPLY/SAMPLE only)
//   dut_in1..3  gate inputs, {dut_in1,dut_in2,dut_in3} = current row
//   dut_out     gate response
//   busy        high while in APPLY or SAMPLE
//   done        one-cycle pulse after a completed sweep
//   table_out   captured truth table
//   table_valid table_out holds a complete sweep
//
// Optional feature (macro TRUTH_TABLE_SWEEPER_CHECK_EN):
//   expected    reference truth table
//   pass / fail registered comparison of table_out against expected, produced
//               when a sweep completes. Both are cleared by an accepted start,
//               an accepted abort, or rst.
//
// Handshake: start is sampled on a rising edge while IDLE. If abort is high on
// the same edge, abort wins and no sweep starts. done rises one edge after the
// DONE state is entered, so it appears 8*(SETTLE+1)+1 edges after the start
// edge.
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       table_valid
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    ,
    input  logic [7:0] expected,
    output logic       pass,
    output logic       fail
`endif
);

    // A SETTLE of 0 behaves as 1, so every row is held for at least one cycle.
    localparam logic [7:0] SETTLE_EFF = (SETTLE == 0) ? 8'd1 : 8'(SETTLE);
    localparam logic [7:0] CNT_LAST   = SETTLE_EFF - 8'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] row;
    logic [7:0] cnt;
    logic       start_ok;
    logic       abort_ok;

    // Accepted events, shared by the FSM and the datapath registers.
    assign start_ok = (state == IDLE) && start && !abort;
    assign abort_ok = ((state == APPLY) || (state == SAMPLE)) && abort;

    // The row register drives the gate directly; it is 0 in IDLE and DONE.
    assign {dut_in1, dut_in2, dut_in3} = row;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (row == 3'd7) begin
                    state_next = DONE;
                end else begin
                    state_next = APPLY;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= 3'd0;
            cnt         <= 8'd0;
            done        <= 1'b0;
            table_valid <= 1'b0;
            table_out   <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        row         <= 3'd0;
                        cnt         <= 8'd0;
                        table_valid <= 1'b0;
                        table_out   <= 8'h00;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        row <= 3'd0;
                        cnt <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    // An abort here drops the pending sample; bits already
                    // captured stay in table_out.
                    if (abort) begin
                        row <= 3'd0;
                        cnt <= 8'd0;
                    end else begin
                        table_out[3'd7 - row] <= dut_out;
                        cnt                   <= 8'd0;
                        row                   <= (row == 3'd7) ? 3'd0 : row + 3'd1;
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    table_valid <= 1'b1;
                end
                default: begin
                    row <= 3'd0;
                    cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    // table_out is final by the time DONE is reached, so it is compared there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else if (start_ok || abort_ok) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else if (state == DONE) begin
            pass <= (table_out == expected);
            fail <= (table_out != expected);
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       dut_in1, dut_in2, dut_in3;
    logic       dut_out;
    logic       busy, done, table_valid;
    logic [7:0] table_out;
    logic [7:0] gate_tt;
    logic [2:0] dut_in;

    // Second instance with SETTLE=0, which must behave as SETTLE=1.
    logic       start2;
    logic       b_in1, b_in2, b_in3;
    logic       dut_out2;
    logic       busy2, done2, table_valid2;
    logic [7:0] table_out2;
    logic [2:0] dut_in_b;

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    logic [7:0] expected;
    logic       pass, fail;
    logic       pass2, fail2;
`endif

    int n_checks;
    int n_fail;

    assign dut_in   = {dut_in1, dut_in2, dut_in3};
    assign dut_in_b = {b_in1, b_in2, b_in3};
    // Gate model: row 000 is the MSB of its truth table.
    assign dut_out  = gate_tt[3'd7 - dut_in];
    assign dut_out2 = gate_tt[3'd7 - dut_in_b];

    truth_table_sweeper #(.SETTLE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_in1(dut_in1), .dut_in2(dut_in2), .dut_in3(dut_in3),
        .dut_out(dut_out), .busy(busy), .done(done),
        .table_out(table_out), .table_valid(table_valid)
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        , .expected(expected), .pass(pass), .fail(fail)
`endif
    );

    truth_table_sweeper #(.SETTLE(0)) dut_clamp (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .dut_in1(b_in1), .dut_in2(b_in2), .dut_in3(b_in3),
        .dut_out(dut_out2), .busy(busy2), .done(done2),
        .table_out(table_out2), .table_valid(table_valid2)
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        , .expected(8'h00), .pass(pass2), .fail(fail2)
`endif
    );

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ checker
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ drivers
    // Runs one sweep on the SETTLE=4 instance. The reference is derived from
    // the rules: row r is shown during cycles 5r..5r+4 after the start edge,
    // busy lasts 40 cycles, done rises at edge 41, table equals the gate's.
    // extra_start >= 1 re-pulses start on that edge (must be ignored).
    task automatic do_sweep(input logic [7:0] tt, input logic [7:0] exp_table,
                            input int extra_start, input string tag);
        int busy_cnt;
        int done_cnt;
        int done_edge;
        bit seq_bad;
        gate_tt = tt;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_edge = -1;
        seq_bad   = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;          // edge 0 has sampled start
        start = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            if (busy) busy_cnt++;
            if (e - 1 < 40) begin
                if (busy !== 1'b1 || dut_in !== 3'((e - 1) / 5)) seq_bad = 1;
            end else if (dut_in !== 3'd0) begin
                seq_bad = 1;
            end
            start = (e == extra_start);
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
        end
        start = 1'b0;
        check({tag, " done_edge"}, done_edge, 41);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " busy_cycles"}, busy_cnt, 40);
        check({tag, " dut_in_seq"}, 32'(seq_bad), 0);
        check({tag, " table_out"}, table_out, exp_table);
        check({tag, " table_valid"}, table_valid, 1);
    endtask

    typedef struct {
        logic [7:0] gate;
        logic [7:0] exp_table;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] held;
    logic [7:0] rnd;
    int         e2;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{8'h7B, 8'h7B};
        vecs[1] = '{8'hFF, 8'hFF};   // gate tied to 1
        vecs[2] = '{8'h00, 8'h00};   // gate tied to 0
        vecs[3] = '{8'h81, 8'h81};
        vecs[4] = '{8'h5A, 8'h5A};

        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; gate_tt = 8'h7B;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        expected = 8'h7B;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset table", {table_valid, table_out}, 0);
        check("reset dut_in", dut_in, 0);
        rst = 1'b0;

        // Table-driven full sweeps.
        for (int i = 0; i < 5; i++) begin
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
            expected = vecs[i].exp_table;
`endif
            do_sweep(vecs[i].gate, vecs[i].exp_table, 0, $sformatf("vec%0d", i));
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
            check("pass match", {pass, fail}, 2'b10);
`endif
        end

        // Result is held stable in IDLE.
        held = table_out;
        repeat (10) @(posedge clk);
        #1;
        check("idle hold table", table_out, held);
        check("idle hold valid", table_valid, 1);

        // start with abort in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check("start+abort busy", busy, 0);
        check("start+abort valid", table_valid, 1);
        check("start+abort table", table_out, held);

        // Second start at cycle 10 is ignored.
        do_sweep(8'h7B, 8'h7B, 10, "restart");

        // Mismatching expected value.
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        expected = 8'h7A;
        do_sweep(8'h7B, 8'h7B, 0, "chk_bad");
        check("pass mismatch", {pass, fail}, 2'b01);
`endif

        // Abort at cycle 20.
        gate_tt = 8'h7B;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort dut_in", dut_in, 0);
        check("abort valid", table_valid, 0);
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        check("abort pass/fail", {pass, fail}, 2'b00);
`endif
        e2 = 0;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            if (done || busy) e2++;
        end
        check("abort quiet", e2, 0);

        // Reset mid-sweep at cycle 15, without a clock edge.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst table", {table_valid, table_out}, 0);
        check("rst dut_in", dut_in, 0);
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        expected = 8'h7B;
`endif
        do_sweep(8'h7B, 8'h7B, 0, "after_rst");

        // Randomized gates, some with a spurious start mid-sweep.
        for (int i = 0; i < 4; i++) begin
            rnd = 8'($urandom);
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
            expected = rnd;
`endif
            do_sweep(rnd, rnd, int'($urandom_range(0, 39)), $sformatf("rnd%0d", i));
        end

        // SETTLE=0 clamps to 1: two cycles per row, done at edge 17.
        gate_tt = 8'hC5;
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        e2 = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (done2 && e2 < 0) e2 = e;
        end
        check("clamp done_edge", e2, 17);
        check("clamp table", table_out2, 8'hC5);
        check("clamp valid", table_valid2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
